ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. Sends command bytes (LED set 0xED, reset 0xFF, enable 0xF4, ...) from the FPGA to the keyboard over the shared open-drain PS2C/PS2D lines. It sits beside the existing keyboard receiver on the same pins. It owns the lines only while busy=1; the receiver gates its input with busy.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_host_tx_if.sv | 26 ++
 rtl/ps2_line_filter.sv | 52 +++++
 rtl/ps2_host_tx.sv | 141 ++++++++++++++
 tb/tb_ps2_host_tx.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared types, constants and frame helpers for the PS/2 host transmitter.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_state_t;

    localparam logic [7:0] CMD_LED    = 8'hED;
    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] ACK_BYTE   = 8'hFA;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // {stop, parity, data}, shifted out LSB first after the start bit
    function automatic logic [9:0] tx_frame(input logic [7:0] d);
        return {1'b1, odd_parity(d), d};
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester and the PS/2 host transmitter.
interface ps2_host_tx_if;

    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       tx_done;
    logic       tx_err;

    modport master (
        output tx_start,
        output tx_data,
        input  busy,
        input  tx_done,
        input  tx_err
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output busy,
        output tx_done,
        output tx_err
    );

endinterface

// File: rtl/ps2_line_filter.sv
// Pad synchroniser plus run-length glitch filter with a falling-edge strobe.
module ps2_line_filter #(
    parameter int FILT_DIV = 4,
    parameter int FILT_LEN = 8
) (
    input  logic clk,
    input  logic clr,
    input  logic raw,
    output logic filt,
    output logic fall
);

    localparam int DW = (FILT_DIV > 1) ? $clog2(FILT_DIV) : 1;
    localparam int LW = $clog2(FILT_LEN + 1);
    localparam logic [DW-1:0] DIV_M1 = DW'(FILT_DIV - 1);
    localparam logic [LW-1:0] LEN_M1 = LW'(FILT_LEN - 1);

    logic [1:0]    sync;
    logic [DW-1:0] div;
    logic [LW-1:0] run;
    logic          filt_q;
    logic          tick;

    assign tick = (div == DIV_M1);
    assign fall = filt_q & ~filt;

    always_ff @(posedge clk) begin
        if (!clr) begin
            sync   <= 2'b11;
            div    <= '0;
            run    <= '0;
            filt   <= 1'b1;
            filt_q <= 1'b1;
        end else begin
            sync   <= {sync[0], raw};
            filt_q <= filt;
            div    <= tick ? '0 : div + 1'b1;
            // run counts consecutive samples that disagree with filt
            if (tick) begin
                if (sync[1] == filt) begin
                    run <= '0;
                end else if (run == LEN_M1) begin
                    filt <= sync[1];
                    run  <= '0;
                end else begin
                    run <= run + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start, data, parity, stop, ACK.
// Owns the open-drain PS2C/PS2D lines only while busy.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC = 12000,
    parameter int TIMEOUT_CYC = 2000000,
    parameter int FILT_DIV    = 4,
    parameter int FILT_LEN    = 8
) (
    input  logic         clk,
    input  logic         clr,
    ps2_host_tx_if.slave host,
    input  logic         ps2c_in,
    input  logic         ps2d_in,
    output logic         ps2c_oe,
    output logic         ps2d_oe
);

    localparam int MAXC = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] INH_M2 = CW'(INHIBIT_CYC - 2);
    localparam logic [CW-1:0] INH_M1 = CW'(INHIBIT_CYC - 1);
    localparam logic [CW-1:0] TO_M1  = CW'(TIMEOUT_CYC - 1);

    ps2_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    bitcnt, bitcnt_n;
    logic [9:0]    frame, frame_n;
    logic          c_oe_n, d_oe_n, busy_n, done_n, err_n;
    logic          c_filt, d_filt, fall_c, unused_d_fall;
    logic          wd_on;

    ps2_line_filter #(.FILT_DIV(FILT_DIV), .FILT_LEN(FILT_LEN)) u_filt_c (
        .clk  (clk),
        .clr  (clr),
        .raw  (ps2c_in),
        .filt (c_filt),
        .fall (fall_c)
    );

    ps2_line_filter #(.FILT_DIV(FILT_DIV), .FILT_LEN(FILT_LEN)) u_filt_d (
        .clk  (clk),
        .clr  (clr),
        .raw  (ps2d_in),
        .filt (d_filt),
        .fall (unused_d_fall)
    );

    assign wd_on = (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bitcnt_n = bitcnt;
        frame_n  = frame;
        d_oe_n   = ps2d_oe;
        done_n   = 1'b0;
        err_n    = 1'b0;
        unique case (state)
            IDLE: begin
                d_oe_n = 1'b0;
                if (host.tx_start) begin
                    frame_n = tx_frame(host.tx_data);
                    cnt_n   = '0;
                    state_n = INHIBIT;
                end
            end
            INHIBIT: begin
                cnt_n = cnt + 1'b1;
                // start bit goes low one clk before the clock is released
                if (cnt == INH_M2) d_oe_n = 1'b1;
                if (cnt == INH_M1) begin
                    cnt_n    = '0;
                    bitcnt_n = '0;
                    state_n  = SHIFT;
                end
            end
            SHIFT: begin
                cnt_n = cnt + 1'b1;
                if (fall_c) begin
                    d_oe_n   = ~frame[bitcnt];
                    bitcnt_n = bitcnt + 1'b1;
                    if (bitcnt == 4'd9) state_n = ACK;
                end
            end
            ACK: begin
                cnt_n = cnt + 1'b1;
                if (fall_c) begin
                    if (d_filt) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_n = cnt + 1'b1;
                if (c_filt && d_filt) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (wd_on && (cnt == TO_M1)) begin
            done_n  = 1'b0;
            err_n   = 1'b1;
            state_n = IDLE;
        end
        if (state_n == IDLE) d_oe_n = 1'b0;
        c_oe_n = (state_n == INHIBIT);
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state        <= IDLE;
            cnt          <= '0;
            bitcnt       <= '0;
            frame        <= '0;
            ps2c_oe      <= 1'b0;
            ps2d_oe      <= 1'b0;
            host.busy    <= 1'b0;
            host.tx_done <= 1'b0;
            host.tx_err  <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            bitcnt       <= bitcnt_n;
            frame        <= frame_n;
            ps2c_oe      <= c_oe_n;
            ps2d_oe      <= d_oe_n;
            host.busy    <= busy_n;
            host.tx_done <= done_n;
            host.tx_err  <= err_n;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a device-side model clocks frames and answers
// ACK/NACK; expected frames and outcomes flow through a scoreboard queue.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 200;
    localparam int TO   = 3000;
    localparam int FDIV = 4;
    localparam int FLEN = 8;
    localparam int HALF = 100;

    typedef struct {
        logic [7:0] data;
        logic       par;
        bit         ack;
        int         glitch;
        int         ign;
    } vec_t;

    typedef struct {
        logic [10:0] bits;
        bit          done;
        bit          err;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b0;
    logic dev_c = 1'b1;
    logic dev_d = 1'b1;
    logic ps2c_in, ps2d_in, ps2c_oe, ps2d_oe;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    exp_t sb[$];
    vec_t vecs[5];

    ps2_host_tx_if host();

    always #5 clk = ~clk;

    assign ps2c_in = dev_c & ~ps2c_oe;
    assign ps2d_in = dev_d & ~ps2d_oe;

    ps2_host_tx #(
        .INHIBIT_CYC (INH),
        .TIMEOUT_CYC (TO),
        .FILT_DIV    (FDIV),
        .FILT_LEN    (FLEN)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .host    (host),
        .ps2c_in (ps2c_in),
        .ps2d_in (ps2d_in),
        .ps2c_oe (ps2c_oe),
        .ps2d_oe (ps2d_oe)
    );

    always @(posedge clk) begin
        if (host.tx_done) done_cnt <= done_cnt + 1;
        if (host.tx_err) err_cnt <= err_cnt + 1;
        if (host.tx_done && host.tx_err) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        host.tx_start = 1'b1;
        host.tx_data  = d;
        @(negedge clk);
        host.tx_start = 1'b0;
    endtask

    task automatic dev_rx(input bit ack, input int glitch, input int ign,
                          input int rst_at, output logic [10:0] bits,
                          output bit aborted);
        int n;
        int hi;
        bits = 'x;
        aborted = 1'b0;
        n = 0;
        while (!ps2c_oe && n < 50) begin
            @(negedge clk);
            n++;
        end
        hi = 0;
        while (ps2c_oe && hi < INH + 50) begin
            @(negedge clk);
            hi++;
        end
        check("inhibit_len", hi, INH);
        repeat (HALF) @(negedge clk);
        bits[0] = ps2d_in;
        for (int i = 1; i <= 10; i++) begin
            dev_c = 1'b0;
            repeat (HALF) @(negedge clk);
            bits[i] = ps2d_in;
            dev_c = 1'b1;
            if (i == rst_at) begin
                repeat (10) @(negedge clk);
                check("pre_reset", {host.busy, ps2d_oe}, 2'b11);
                clr = 1'b0;
                @(negedge clk);
                check("reset_release", {host.busy, ps2c_oe, ps2d_oe}, 0);
                clr = 1'b1;
                aborted = 1'b1;
                return;
            end
            repeat (HALF / 2) @(negedge clk);
            if (i == glitch) begin
                dev_c = 1'b0;
                repeat (3 * FDIV) @(negedge clk);
                dev_c = 1'b1;
            end
            if (i == ign) begin
                host.tx_start = 1'b1;
                host.tx_data  = 8'h00;
                @(negedge clk);
                host.tx_start = 1'b0;
                check("ign_busy", host.busy, 1);
            end
            repeat (HALF / 2) @(negedge clk);
        end
        if (ack) dev_d = 1'b0;
        repeat (HALF / 2) @(negedge clk);
        dev_c = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_c = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_d = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        exp_t e;
        exp_t got;
        logic [10:0] bits;
        bit ab;
        int d0;
        int e0;
        int n;
        e.bits = {1'b1, v.par, v.data, 1'b0};
        e.done = v.ack;
        e.err  = !v.ack;
        d0 = done_cnt;
        e0 = err_cnt;
        send(v.data);
        sb.push_back(e);
        dev_rx(v.ack, v.glitch, v.ign, 0, bits, ab);
        n = 0;
        while (host.busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check({tag, "_busy_end"}, host.busy, 0);
        got = sb.pop_front();
        check({tag, "_bits"}, bits, got.bits);
        check({tag, "_done"}, done_cnt - d0, got.done);
        check({tag, "_err"}, err_cnt - e0, got.err);
        check({tag, "_oe_idle"}, {ps2c_oe, ps2d_oe}, 0);
        if (v.ign != 0) begin
            repeat (300) @(negedge clk);
            check({tag, "_no_queue"}, {host.busy, ps2c_oe}, 0);
        end
    endtask

    initial begin
        logic [10:0] bits;
        bit ab;
        int n;
        vec_t gv;

        host.tx_start = 1'b0;
        host.tx_data  = 8'h00;
        vecs[0] = '{8'hED, 1'b1, 1'b1, 0, 0};
        vecs[1] = '{8'hF4, 1'b0, 1'b1, 0, 0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 0, 0};
        vecs[3] = '{8'hA5, 1'b1, 1'b0, 0, 0};
        vecs[4] = '{8'h5B, 1'b0, 1'b1, 0, 3};

        clr = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_busy", host.busy, 0);
        check("reset_oe", {ps2c_oe, ps2d_oe}, 0);
        check("reset_pulses", {host.tx_done, host.tx_err}, 0);
        clr = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        send(CMD_LED);
        dev_rx(1'b1, 0, 0, 5, bits, ab);
        check("reset_abort", ab, 1);
        repeat (20) @(negedge clk);

        gv = '{CMD_LED, 1'b1, 1'b1, 4, 0};
        run_vec(gv, "glitch");

        send(8'h12);
        n = 0;
        while (ps2c_oe && n < INH + 50) begin
            @(negedge clk);
            n++;
        end
        check("to_start_bit", ps2d_oe, 1);
        n = 0;
        while (!host.tx_err && n < TO + 200) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cyc", n, TO);
        check("timeout_release", {ps2c_oe, ps2d_oe, host.busy}, 0);
        repeat (5) @(negedge clk);

        @(negedge clk);
        clr = 1'b0;
        host.tx_start = 1'b1;
        host.tx_data  = CMD_RESET;
        @(negedge clk);
        check("reset_beats_start", {host.busy, ps2c_oe}, 0);
        clr = 1'b1;
        host.tx_start = 1'b0;
        repeat (5) @(negedge clk);
        check("still_idle", {host.busy, ps2c_oe}, 0);

        check("done_err_exclusive", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
